// File: rtl/branch_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit counter encodings with
// saturating helpers, flush FSM states and the branch unit's op encodings.
package branch_pkg;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } cnt_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    typedef enum logic [2:0] {
        BR_NEVER  = 3'd0,
        BR_ALWAYS = 3'd1,
        BR_EQ     = 3'd2,
        BR_NE     = 3'd3,
        BR_LT     = 3'd4,
        BR_GE     = 3'd5,
        BR_LTU    = 3'd6,
        BR_GEU    = 3'd7
    } branch_op_t;

    function automatic cnt_t cnt_inc(cnt_t c);
        return (c == CNT_STRONG_T) ? CNT_STRONG_T : cnt_t'(c + 2'd1);
    endfunction

    function automatic cnt_t cnt_dec(cnt_t c);
        return (c == CNT_STRONG_NT) ? CNT_STRONG_NT : cnt_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Direct-mapped BTB storage: valid/tag/counter/target per entry, one async read port,
// one training write port (read-modify-write on its own index) and a valid-clear port.
module bp_counter_table
    import branch_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 12
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output cnt_t             rd_cnt,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic             wr_uncond,
    input  logic [XLEN-1:0]  wr_target,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    cnt_t               cnt_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic wr_hit;
    logic train;
    logic alloc;
    logic target_we;
    cnt_t next_cnt;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_cnt    = cnt_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign train     = wr_en && wr_hit;
    assign alloc     = wr_en && !wr_hit && wr_taken;
    assign target_we = (train && wr_taken) || alloc;

    always_comb begin
        next_cnt = cnt_q[wr_idx];
        if (train) begin
            if (wr_uncond)     next_cnt = CNT_STRONG_T;
            else if (wr_taken) next_cnt = cnt_inc(cnt_q[wr_idx]);
            else               next_cnt = cnt_dec(cnt_q[wr_idx]);
        end else if (alloc) begin
            next_cnt = wr_uncond ? CNT_STRONG_T : CNT_WEAK_T;
        end
    end

    // Clear and allocate never coincide: the top drops training while a flush sweeps.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
        end else if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end else if (alloc) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // NOTE: payload arrays carry no reset; valid_q alone gates their use, so the
    // large tag/counter/target storage stays plain flops/RAM without a reset tree.
    always_ff @(posedge clk_in) begin
        if (train || alloc) cnt_q[wr_idx]    <= next_cnt;
        if (alloc)          tag_q[wr_idx]    <= wr_tag;
        if (target_we)      target_q[wr_idx] <= wr_target;
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: registered BTB lookup, execute-side training,
// sequenced table flush and a saturating mispredict counter.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 12,
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             lookup_valid_in,
    input  logic [XLEN-1:0]  lookup_pc_in,
    output logic             pred_valid_out,
    output logic             pred_hit_out,
    output logic             pred_taken_out,
    output logic [XLEN-1:0]  pred_target_out,
    input  logic             update_valid_in,
    input  logic [XLEN-1:0]  update_pc_in,
    input  logic             update_taken_in,
    input  logic             update_uncond_in,
    input  logic [XLEN-1:0]  update_target_in,
    input  logic             update_mispredicted_in,
    input  logic             flush_in,
    output logic             busy_out,
    output logic [CNT_W-1:0] mispredict_count_out
);

    flush_state_t     state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             clr_en;
    logic             busy;

    logic [IDX_W-1:0] lookup_idx, update_idx;
    logic [TAG_W-1:0] lookup_tag, update_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    cnt_t             rd_cnt;
    logic [XLEN-1:0]  rd_target;
    logic             hit_d;

    assign lookup_idx = lookup_pc_in[IDX_W+1:2];
    assign lookup_tag = lookup_pc_in[IDX_W+TAG_W+1:IDX_W+2];
    assign update_idx = update_pc_in[IDX_W+1:2];
    assign update_tag = update_pc_in[IDX_W+TAG_W+1:IDX_W+2];

    logic unused_bits;
    assign unused_bits = ^{lookup_pc_in[XLEN-1:IDX_W+TAG_W+2], lookup_pc_in[1:0],
                           update_pc_in[XLEN-1:IDX_W+TAG_W+2], update_pc_in[1:0], rd_cnt[0]};

    assign busy     = (state_q == ST_FLUSH);
    assign busy_out = busy;

    bp_counter_table #(
        .XLEN  (XLEN),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_table (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rd_idx    (lookup_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_cnt    (rd_cnt),
        .rd_target (rd_target),
        .wr_en     (update_valid_in && !busy),
        .wr_idx    (update_idx),
        .wr_tag    (update_tag),
        .wr_taken  (update_taken_in),
        .wr_uncond (update_uncond_in),
        .wr_target (update_target_in),
        .clr_en    (clr_en),
        .clr_idx   (ptr_q)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_in) begin
                    state_d = ST_FLUSH;
                    ptr_d   = '0;
                end
            end
            ST_FLUSH: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + IDX_W'(1);
                if (&ptr_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, which also gives the table its read-before-write behaviour.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign hit_d = lookup_valid_in && !busy && rd_valid && (rd_tag == lookup_tag);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pred_valid_out  <= 1'b0;
            pred_hit_out    <= 1'b0;
            pred_taken_out  <= 1'b0;
            pred_target_out <= '0;
        end else begin
            pred_valid_out  <= lookup_valid_in;
            pred_hit_out    <= hit_d;
            pred_taken_out  <= hit_d && rd_cnt[1];
            pred_target_out <= hit_d ? rd_target : '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mispredict_count_out <= '0;
        end else if (update_valid_in && update_mispredicted_in && !(&mispredict_count_out)) begin
            mispredict_count_out <= mispredict_count_out + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised scoreboard bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

    localparam int XLEN    = 64;
    localparam int IDX_W   = 6;
    localparam int TAG_W   = 12;
    localparam int CNT_W   = 32;
    localparam int ENTRIES = 64;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            lookup_valid_in;
    logic [XLEN-1:0] lookup_pc_in;
    logic            pred_valid_out, pred_hit_out, pred_taken_out;
    logic [XLEN-1:0] pred_target_out;
    logic            update_valid_in;
    logic [XLEN-1:0] update_pc_in;
    logic            update_taken_in, update_uncond_in;
    logic [XLEN-1:0] update_target_in;
    logic            update_mispredicted_in;
    logic            flush_in;
    logic            busy_out;
    logic [CNT_W-1:0] mispredict_count_out;

    logic            s_pred_valid, s_pred_hit, s_pred_taken;
    logic [XLEN-1:0] s_pred_target;
    logic            s_busy;
    logic [1:0]      s_count;

    always #5 clk_in = ~clk_in;

    branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .lookup_valid_in(lookup_valid_in), .lookup_pc_in(lookup_pc_in),
        .pred_valid_out(pred_valid_out), .pred_hit_out(pred_hit_out),
        .pred_taken_out(pred_taken_out), .pred_target_out(pred_target_out),
        .update_valid_in(update_valid_in), .update_pc_in(update_pc_in),
        .update_taken_in(update_taken_in), .update_uncond_in(update_uncond_in),
        .update_target_in(update_target_in), .update_mispredicted_in(update_mispredicted_in),
        .flush_in(flush_in), .busy_out(busy_out), .mispredict_count_out(mispredict_count_out)
    );

    // Narrow-counter instance to observe saturation of the mispredict count.
    branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(2)) dut_small (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .lookup_valid_in(lookup_valid_in), .lookup_pc_in(lookup_pc_in),
        .pred_valid_out(s_pred_valid), .pred_hit_out(s_pred_hit),
        .pred_taken_out(s_pred_taken), .pred_target_out(s_pred_target),
        .update_valid_in(update_valid_in), .update_pc_in(update_pc_in),
        .update_taken_in(update_taken_in), .update_uncond_in(update_uncond_in),
        .update_target_in(update_target_in), .update_mispredicted_in(update_mispredicted_in),
        .flush_in(flush_in), .busy_out(s_busy), .mispredict_count_out(s_count)
    );

    typedef struct {
        bit              hit;
        bit              taken;
        logic [XLEN-1:0] target;
    } pred_t;

    pred_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    // Reference model: one record per table slot, counter kept as a plain 0..3 integer.
    bit              m_valid [ENTRIES];
    int unsigned     m_tag   [ENTRIES];
    int              m_cnt   [ENTRIES];
    logic [XLEN-1:0] m_tgt   [ENTRIES];
    int              flush_rem = 0;
    longint unsigned m_mis  = 0;
    int              m_mis2 = 0;

    task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(logic [XLEN-1:0] pc);
        return int'((pc >> (2 + IDX_W)) % (64'd1 << TAG_W));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_train(logic [XLEN-1:0] pc, bit taken, bit uncond,
                                        logic [XLEN-1:0] tgt);
        int i;
        i = idx_of(pc);
        if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
            if (uncond)     m_cnt[i] = 3;
            else if (taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            else            m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            if (taken) m_tgt[i] = tgt;
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_cnt[i]   = uncond ? 3 : 2;
        end
    endfunction

    // One clock of stimulus; the expectation is computed from pre-edge model state.
    task automatic cycle(bit lv, logic [XLEN-1:0] lpc, bit uv, logic [XLEN-1:0] upc,
                         bit ut, bit uu, logic [XLEN-1:0] utgt, bit um, bit fl);
        pred_t p;
        int    i;
        bit    busy;
        busy = (flush_rem > 0);
        lookup_valid_in        = lv;
        lookup_pc_in           = lpc;
        update_valid_in        = uv;
        update_pc_in           = upc;
        update_taken_in        = ut;
        update_uncond_in       = uu;
        update_target_in       = utgt;
        update_mispredicted_in = um;
        flush_in               = fl;
        if (lv) begin
            i        = idx_of(lpc);
            p.hit    = !busy && m_valid[i] && (m_tag[i] == tag_of(lpc));
            p.taken  = p.hit && (m_cnt[i] >= 2);
            p.target = p.hit ? m_tgt[i] : '0;
            exp_q.push_back(p);
        end
        if (uv && !busy) model_train(upc, ut, uu, utgt);
        if (uv && um) begin
            if (m_mis != 64'h0000_0000_FFFF_FFFF) m_mis++;
            if (m_mis2 < 3) m_mis2++;
        end
        if (busy) flush_rem--;
        else if (fl) begin
            flush_rem = ENTRIES;
            model_clear();
        end
        @(posedge clk_in);
        #1;
        check("busy", busy_out, flush_rem > 0);
        check("mis_count", mispredict_count_out, m_mis);
        check("mis_count_w2", s_count, m_mis2);
    endtask

    task automatic idle();
        cycle(0, '0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    task automatic lookup(logic [XLEN-1:0] pc);
        cycle(1, pc, 0, '0, 0, 0, '0, 0, 0);
    endtask

    task automatic train(logic [XLEN-1:0] pc, bit taken, bit uncond, logic [XLEN-1:0] tgt, bit mis);
        cycle(0, '0, 1, pc, taken, uncond, tgt, mis, 0);
    endtask

    function automatic logic [XLEN-1:0] rand_pc();
        logic [XLEN-1:0] t, ix, lo;
        t  = XLEN'($urandom_range(0, 3));
        ix = XLEN'($urandom_range(0, 7));
        lo = XLEN'($urandom_range(0, 3));
        return (t << (IDX_W + 2)) | (ix << 2) | lo;
    endfunction

    // Monitor: pops one expectation per presented prediction.
    initial begin
        pred_t e;
        wait (mon_en);
        forever begin
            @(negedge clk_in);
            if (pred_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pred", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("pred_hit", pred_hit_out, e.hit);
                    check("pred_taken", pred_taken_out, e.taken);
                    check("pred_target", pred_target_out, e.target);
                end
            end else begin
                check("idle_hit", pred_hit_out, 1'b0);
                check("idle_target", pred_target_out, '0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst_n_in = 1'b0;
        lookup_valid_in = 0; lookup_pc_in = '0; update_valid_in = 0; update_pc_in = '0;
        update_taken_in = 0; update_uncond_in = 0; update_target_in = '0;
        update_mispredicted_in = 0; flush_in = 0;
        model_clear();
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_pred_valid", pred_valid_out, 1'b0);
        check("rst_pred_hit", pred_hit_out, 1'b0);
        check("rst_pred_taken", pred_taken_out, 1'b0);
        check("rst_pred_target", pred_target_out, '0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_count", mispredict_count_out, '0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        mon_en = 1'b1;

        // Cold miss, allocate, then three not-taken trainings saturating at 00.
        lookup(64'h1000);
        train(64'h1000, 1, 0, 64'h2000, 0);
        lookup(64'h1000);
        for (int k = 0; k < 3; k++) train(64'h1000, 0, 0, '0, 0);
        lookup(64'h1000);

        // Mispredict pulses on five updates.
        for (int k = 0; k < 5; k++) train(64'h4000 + 64'(k * 4), 0, 0, '0, 1);
        check("mis_five", mispredict_count_out, 64'd5);
        check("mis_sat_w2", s_count, 2'd3);

        // Aliasing: same index, different tag.
        train(64'h1000, 1, 0, 64'h2000, 0);
        lookup(64'h1000 + ENTRIES * 4);
        train(64'h1000 + ENTRIES * 4, 1, 0, 64'h5000, 0);
        lookup(64'h1000);
        lookup(64'h1000 + ENTRIES * 4);

        // Read-before-write with counter at weak not-taken.
        train(64'h1000, 1, 0, 64'h2000, 0);
        train(64'h1000, 0, 0, '0, 0);
        cycle(1, 64'h1000, 1, 64'h1000, 1, 0, 64'h2400, 0, 0);
        lookup(64'h1000);
        train(64'h1008, 1, 1, 64'h7000, 0);
        lookup(64'h1008);

        // Flush: measure busy length, drop a mid-sweep update, then everything misses.
        cycle(0, '0, 0, '0, 0, 0, '0, 0, 1);
        nb = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy_out) break;
            nb++;
            if (k == 10)      cycle(1, 64'h1000, 1, 64'h3000, 1, 0, 64'h9000, 0, 0);
            else if (k == 20) cycle(1, 64'h1008, 0, '0, 0, 0, '0, 0, 1);
            else              idle();
        end
        check("flush_len", nb, ENTRIES);
        lookup(64'h1000);
        lookup(64'h1008);
        lookup(64'h3000);

        // Randomised traffic.
        for (int k = 0; k < 2000; k++) begin
            cycle($urandom_range(0, 1), rand_pc(), $urandom_range(0, 1), rand_pc(),
                  $urandom_range(0, 1), ($urandom_range(0, 7) == 0), XLEN'({$urandom, $urandom}),
                  $urandom_range(0, 1), ($urandom_range(0, 299) == 0));
        end
        while (flush_rem > 0) idle();

        // Asynchronous reset in the middle of a flush.
        train(64'h1000, 1, 0, 64'h2000, 0);
        cycle(0, '0, 0, '0, 0, 0, '0, 0, 1);
        repeat (5) idle();
        rst_n_in = 1'b0;
        #2;
        check("midflush_rst_busy", busy_out, 1'b0);
        check("midflush_rst_count", mispredict_count_out, '0);
        model_clear();
        flush_rem = 0;
        m_mis = 0;
        m_mis2 = 0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        lookup(64'h1000);
        train(64'h1000, 1, 0, 64'h2222, 1);
        lookup(64'h1000);
        idle();
        idle();
        check("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the fetch stage. It replaces static "predict by op" with a direct-mapped branch target buffer (BTB) and a 2-bit saturating-counter history table.
- Fetch presents a PC and receives a registered taken/target prediction one cycle later.
- Execute sends resolved outcomes from the branch unit back to train the table.
- A sequenced flush clears the table, for example on a context switch or fence.

Parameters:
- XLEN, 64, width of PC and target.
- IDX_W, 6, index bits; ENTRIES = 2**IDX_W.
- TAG_W, 12, tag bits stored per entry.
- CNT_W, 32, width of the saturating mispredict counter.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- lookup_valid_in  input  1  fetch lookup request.
- lookup_pc_in  input  XLEN  PC to predict.
- pred_valid_out  output  1  prediction valid; registered lookup_valid_in.
- pred_hit_out  output  1  tag hit on a valid entry.
- pred_taken_out  output  1  predicted taken.
- pred_target_out  output  XLEN  predicted target; 0 when pred_hit_out is 0.
- update_valid_in  input  1  resolved branch from execute.
- update_pc_in  input  XLEN  PC of the resolved branch.
- update_taken_in  input  1  actual outcome.
- update_uncond_in  input  1  branch op was ALWAYS (jump).
- update_target_in  input  XLEN  actual target.
- update_mispredicted_in  input  1  branch unit flagged a mispredict.
- flush_in  input  1  request a table clear.
- busy_out  output  1  flush in progress.
- mispredict_count_out  output  CNT_W  saturating mispredict count.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid (1 bit), tag (TAG_W), counter (2 bits), target (XLEN).
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. Predict taken when counter[1] = 1.
- Reset (rst_n_in low, asynchronous):
  - All valid bits = 0; state = IDLE.
  - All outputs = 0, including mispredict_count_out.
  - Tag, counter and target arrays are not reset.
- Lookup, latency 1:
  - On each edge, pred_valid_out <= lookup_valid_in.
  - pred_hit_out <= valid[idx] && tag match.
  - pred_taken_out <= hit && counter[1].
  - pred_target_out <= hit ? target : 0.
  - When lookup_valid_in = 0, the hit, taken and target outputs register 0.
- Update, written at the clock edge:
  - Hit: counter saturating-increments if taken, else saturating-decrements. If taken, target <= update_target_in.
  - Hit with update_uncond_in = 1: counter <= 11.
  - Miss and taken: allocate the entry, overwriting any occupant. Set valid = 1, tag, target, and counter = 10 (11 if uncond).
  - Miss and not taken: no write.
- Same-cycle lookup and update to the same idx: the lookup returns the pre-update contents (read-before-write). The update is visible from the next cycle.
- Mispredict counter:
  - Increments by 1 on update_valid_in && update_mispredicted_in.
  - Saturates at all-ones; no wrap.
  - Counts regardless of FSM state.
- Flush FSM, states IDLE and FLUSH:
  - IDLE to FLUSH on flush_in. The sweep pointer is set to 0 and busy_out = 1 from the next cycle.
  - In FLUSH: clear valid[ptr] each cycle and increment ptr.
  - On ptr == ENTRIES-1, clear the final entry and go to IDLE; busy_out drops the following cycle.
  - A flush takes exactly ENTRIES cycles.
  - flush_in while in FLUSH is ignored; the sweep does not restart.
- While busy_out = 1:
  - Lookups return pred_hit_out = 0 and pred_taken_out = 0. pred_valid_out still tracks the request.
  - Table updates are dropped.
- Reset asserted mid-flush: returns immediately to IDLE with the table invalid.

Decomposition:
- Shared package (branch_pkg), holding:
  - counter encodings and their saturate-increment and saturate-decrement helpers;
  - the FSM state constants;
  - the BRANCH_OP encodings already used by the branch unit.
- One sub-module, bp_counter_table: the ENTRIES-deep valid/tag/counter/target storage with one read port and one write port, plus the valid-clear port.
- The top level holds the FSM, the index and tag decode, and the mispredict counter.

Test Plan:
- Reset, then lookup pc=0x1000 -> one cycle later pred_valid_out=1, pred_hit_out=0, pred_taken_out=0, pred_target_out=0.
- Update pc=0x1000, taken=1, target=0x2000, then lookup pc=0x1000 -> hit=1, taken=1, target=0x2000, counter=10.
- Three not-taken updates at 0x1000 after the allocate -> counter 10 to 01 to 00, saturating at 00; lookup gives taken=0, hit=1.
- Aliasing: allocate 0x1000, then lookup 0x1000 + (ENTRIES*4) -> hit=0. A taken update at the alias overwrites the entry, after which 0x1000 misses.
- Same-cycle lookup and update at 0x1000 with an existing counter=01 and taken=1 -> prediction taken=0; the next lookup gives taken=1.
- Flush with ENTRIES=64 -> busy_out high for exactly 64 cycles; an update during the flush is dropped; all lookups miss afterwards.
- Additionally: a mispredict pulse on 5 updates gives count=5; with CNT_W forced to 2, the count holds at 3.
